// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encodings, opcodes, timing defaults and long-command test for the LCD bus
package lcd_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_EXEC  = 3'd4
  } lcd_state_t;
  localparam logic [7:0] LCD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_HOME = 8'h02;
  localparam int T_SETUP_DEF = 2;
  localparam int T_PULSE_DEF = 12;
  localparam int T_HOLD_DEF = 2;
  localparam int T_EXEC_DEF = 2000;
  localparam int T_EXEC_LONG_DEF = 82000;
  localparam int CNT_W_DEF = 17;
  // Clear (0x01) and Return Home (0x02/0x03, bit 0 is don't-care) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return !rs && (d == LCD_CLEAR || d[7:1] == LCD_HOME[7:1]);
  endfunction
endpackage

// File: rtl/lcd_delay_timer.sv
// lcd_delay_timer: loadable down-counter that parks at zero and flags it
//   Clock, Reset (async, active-low)
//   load     : load load_val this cycle (wins over counting)
//   load_val : value loaded; state lasts load_val+1 cycles until zero
//   zero     : counter is zero
module lcd_delay_timer #(
  parameter int CNT_W = 17
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/lcd_bus_scheduler.sv
// lcd_bus_scheduler: arbitrates init/user writes onto the HD44780 bus with setup/pulse/hold/exec timing
//   Clock, Reset (async, active-low)
//   req_init/init_rs/init_data, gnt_init : high-priority requester, gnt pulses on first SETUP cycle
//   req_user/user_rs/user_data, gnt_user : low-priority requester
//   busy   : transfer in progress (state != IDLE)
//   Enable, RS, RW, Dados : LCD pins (RW tied low, write-only)
//   Estado : FSM state for debug LEDs
module lcd_bus_scheduler
  import lcd_pkg::*;
#(
  parameter int T_SETUP     = T_SETUP_DEF,
  parameter int T_PULSE     = T_PULSE_DEF,
  parameter int T_HOLD      = T_HOLD_DEF,
  parameter int T_EXEC      = T_EXEC_DEF,
  parameter int T_EXEC_LONG = T_EXEC_LONG_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       req_init,
  input  logic       init_rs,
  input  logic [7:0] init_data,
  output logic       gnt_init,
  input  logic       req_user,
  input  logic       user_rs,
  input  logic [7:0] user_data,
  output logic       gnt_user,
  output logic       busy,
  output logic       Enable,
  output logic       RS,
  output logic       RW,
  output logic [7:0] Dados,
  output logic [2:0] Estado
);
  localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] L_PULSE = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] L_HOLD = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] L_EXEC = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] L_EXEC_LONG = CNT_W'(T_EXEC_LONG - 1);
  lcd_state_t state, nxt;
  logic ld, tz, acc_init, acc_user;
  logic [CNT_W-1:0] ld_val;
  lcd_delay_timer #(.CNT_W(CNT_W)) u_tmr (
    .Clock(Clock),
    .Reset(Reset),
    .load(ld),
    .load_val(ld_val),
    .zero(tz)
  );
  always_comb begin
    nxt = state;
    ld = 1'b0;
    ld_val = '0;
    acc_init = 1'b0;
    acc_user = 1'b0;
    case (state)
      ST_IDLE: begin
        acc_init = req_init;
        acc_user = req_user && !req_init;
        ld = req_init || req_user;
        ld_val = L_SETUP;
        nxt = ld ? ST_SETUP : ST_IDLE;
      end
      ST_SETUP: begin
        ld = tz;
        ld_val = L_PULSE;
        nxt = tz ? ST_PULSE : ST_SETUP;
      end
      ST_PULSE: begin
        ld = tz;
        ld_val = L_HOLD;
        nxt = tz ? ST_HOLD : ST_PULSE;
      end
      ST_HOLD: begin
        ld = tz;
        ld_val = is_long_cmd(RS, Dados) ? L_EXEC_LONG : L_EXEC;
        nxt = tz ? ST_EXEC : ST_HOLD;
      end
      ST_EXEC: nxt = tz ? ST_IDLE : ST_EXEC;
      default: nxt = ST_IDLE;
    endcase
  end
  // Outputs are registered from the next state so Enable/busy/gnt align with the state register.
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      state <= ST_IDLE;
      Enable <= 1'b0;
      busy <= 1'b0;
      gnt_init <= 1'b0;
      gnt_user <= 1'b0;
      RS <= 1'b0;
      Dados <= 8'h00;
    end else begin
      state <= nxt;
      Enable <= nxt == ST_PULSE;
      busy <= nxt != ST_IDLE;
      gnt_init <= acc_init;
      gnt_user <= acc_user;
      if (acc_init) begin
        RS <= init_rs;
        Dados <= init_data;
      end else if (acc_user) begin
        RS <= user_rs;
        Dados <= user_data;
      end
    end
  assign RW = 1'b0;
  assign Estado = state;
endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// tb_lcd_bus_scheduler: scoreboard bench for the LCD bus scheduler with shortened timing
module tb_lcd_bus_scheduler;
  logic Clock = 1'b0, Reset = 1'b0;
  logic req_init = 1'b0, init_rs = 1'b0, req_user = 1'b0, user_rs = 1'b0;
  logic [7:0] init_data = 8'h00, user_data = 8'h00;
  logic gnt_init, gnt_user, busy, Enable, RS, RW;
  logic [7:0] Dados;
  logic [2:0] Estado;
  typedef struct {
    bit who;
    bit rs;
    logic [7:0] d;
    int bsy;
    int gap;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  bit done = 1'b0;
  lcd_bus_scheduler #(
    .T_SETUP(2), .T_PULSE(4), .T_HOLD(2), .T_EXEC(10), .T_EXEC_LONG(50), .CNT_W(17)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .req_init(req_init), .init_rs(init_rs), .init_data(init_data), .gnt_init(gnt_init),
    .req_user(req_user), .user_rs(user_rs), .user_data(user_data), .gnt_user(gnt_user),
    .busy(busy), .Enable(Enable), .RS(RS), .RW(RW), .Dados(Dados), .Estado(Estado)
  );
  always #5 Clock = ~Clock;
  function automatic void chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", n, act, act, exp, exp, $time);
    end
  endfunction
  task automatic wait_gnt(input bit who);
    for (int i = 0; i < 200; i++) begin
      @(negedge Clock);
      if (who ? gnt_init : gnt_user) break;
    end
    #1;
    if (who) req_init = 1'b0;
    else req_user = 1'b0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge Clock);
      if (!busy) break;
    end
  endtask
  task automatic xfer(input bit who, input bit rs, input logic [7:0] d, input int bsy);
    q.push_back('{who, rs, d, bsy, 0});
    @(posedge Clock);
    #1;
    if (who) begin
      req_init = 1'b1;
      init_rs = rs;
      init_data = d;
    end else begin
      req_user = 1'b1;
      user_rs = rs;
      user_data = d;
    end
    wait_gnt(who);
    wait_idle();
  endtask
  initial begin
    repeat (3) @(negedge Clock);
    #1 Reset = 1'b1;
    repeat (3) @(negedge Clock);
    q.push_back('{1'b0, 1'b1, 8'h55, 0, 0});
    #1;
    req_user = 1'b1;
    user_rs = 1'b1;
    user_data = 8'h55;
    wait_gnt(1'b0);
    for (int i = 0; i < 50; i++) begin
      if (Enable) break;
      @(negedge Clock);
    end
    @(posedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    #1 Reset = 1'b1;
    repeat (5) @(negedge Clock);
    xfer(1'b0, 1'b1, 8'h41, 18);
    q.push_back('{1'b1, 1'b0, 8'h38, 18, 0});
    q.push_back('{1'b0, 1'b1, 8'h42, 18, 19});
    @(posedge Clock);
    #1;
    req_init = 1'b1;
    init_rs = 1'b0;
    init_data = 8'h38;
    req_user = 1'b1;
    user_rs = 1'b1;
    user_data = 8'h42;
    wait_gnt(1'b1);
    wait_gnt(1'b0);
    wait_idle();
    xfer(1'b1, 1'b0, 8'h01, 58);
    xfer(1'b1, 1'b1, 8'h01, 18);
    xfer(1'b1, 1'b0, 8'h02, 58);
    xfer(1'b1, 1'b0, 8'h03, 58);
    xfer(1'b1, 1'b0, 8'h04, 18);
    xfer(1'b1, 1'b0, 8'h00, 18);
    xfer(1'b0, 1'b0, 8'h01, 58);
    q.push_back('{1'b1, 1'b0, 8'h0C, 18, 0});
    @(posedge Clock);
    #1;
    req_init = 1'b1;
    init_rs = 1'b0;
    init_data = 8'h0C;
    wait_gnt(1'b1);
    @(posedge Clock);
    #1;
    req_user = 1'b1;
    user_data = 8'h77;
    repeat (3) @(posedge Clock);
    #1 req_user = 1'b0;
    wait_idle();
    repeat (25) @(negedge Clock);
    done = 1'b1;
  end
  initial begin
    int cyc = 0, last_g = 0, bcnt = 0, en_n = 0, en_at = 0;
    bit trk = 1'b0, lat_rs = 1'b0;
    logic [7:0] lat_d = 8'h00;
    exp_t e = '{1'b0, 1'b0, 8'h00, 0, 0};
    forever begin
      @(negedge Clock);
      if (done) break;
      if (cyc > 20000) begin
        chk("timeout", cyc, 0);
        break;
      end
      cyc++;
      chk("rw_low", int'(RW), 0);
      if (!Reset) begin
        chk("reset_outs", int'({Enable, busy, Estado, gnt_init, gnt_user, RS, Dados}), 0);
        trk = 1'b0;
        continue;
      end
      if (gnt_init || gnt_user) begin
        if (q.size() == 0) chk("stray_gnt", int'({gnt_init, gnt_user}), 0);
        else begin
          e = q.pop_front();
          chk("gnt_who", int'({gnt_init, gnt_user}), e.who ? 2 : 1);
          chk("rs", int'(RS), int'(e.rs));
          chk("dados", int'(Dados), int'(e.d));
          if (e.gap != 0) chk("gnt_gap", cyc - last_g, e.gap);
          trk = 1'b1;
          bcnt = 0;
          en_n = 0;
          en_at = 0;
          lat_rs = RS;
          lat_d = Dados;
        end
        last_g = cyc;
      end
      if (trk) begin
        if (busy) begin
          bcnt++;
          if (Enable) begin
            en_n++;
            if (en_at == 0) en_at = bcnt;
            chk("stable_in_pulse", int'({RS, Dados}), int'({lat_rs, lat_d}));
          end
        end else begin
          chk("busy_len", bcnt, e.bsy);
          chk("en_len", en_n, 4);
          chk("en_start", en_at, 3);
          chk("estado_idle", int'(Estado), 0);
          trk = 1'b0;
        end
      end else chk("idle_quiet", int'({busy, Enable}), 0);
    end
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
